// File: rtl/vga_scan_gen.sv
// VGA raster generator: counters, sync decode and a registered pixel/sync output stage.
// Optional VGA_SCAN_TEST_PATTERN_EN: 64-pixel colour bars as background for active pixels.
module vga_scan_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  input  logic       draw_in,
  input  logic [5:0] rgb_in,
  output logic       hsync,
  output logic       vsync,
  output logic [5:0] rgb,
  output logic [7:0] uo_out,
  output logic       frame_tick,
  output logic [7:0] frame_cnt
);

  localparam int unsigned CW       = 10;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [CW-1:0] r_h_cnt;
  logic [CW-1:0] r_v_cnt;
  logic [7:0]    r_frame_cnt;
  logic          r_hsync;
  logic          r_vsync;
  logic [5:0]    r_rgb;
  logic          r_frame_tick;

  logic          w_h_last;
  logic          w_v_last;
  logic          w_active;
  logic          w_hs_on;
  logic          w_vs_on;
  logic          w_tick;
  logic [5:0]    w_bg;
  logic [5:0]    w_pix;

  assign w_h_last = (r_h_cnt == CW'(H_TOTAL - 1));
  assign w_v_last = (r_v_cnt == CW'(V_TOTAL - 1));
  assign w_active = (r_h_cnt < CW'(H_ACTIVE)) && (r_v_cnt < CW'(V_ACTIVE));
  assign w_hs_on  = (r_h_cnt >= CW'(HS_START)) && (r_h_cnt < CW'(HS_END));
  assign w_vs_on  = (r_v_cnt >= CW'(VS_START)) && (r_v_cnt < CW'(VS_END));
  assign w_tick   = (r_h_cnt == '0) && (r_v_cnt == CW'(V_ACTIVE));

`ifdef VGA_SCAN_TEST_PATTERN_EN
  assign w_bg = {r_h_cnt[8], r_h_cnt[8], r_h_cnt[7], r_h_cnt[7], r_h_cnt[6], r_h_cnt[6]};
`else
  assign w_bg = 6'b000000;
`endif

  // Blanking is always black; overlay hit wins over the background.
  assign w_pix = w_active ? (draw_in ? rgb_in : w_bg) : 6'b000000;

  // Raster counters and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_frame_cnt <= '0;
    end else if (ena) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        if (w_v_last) begin
          r_v_cnt     <= '0;
          r_frame_cnt <= r_frame_cnt + 8'd1;
        end else begin
          r_v_cnt <= r_v_cnt + CW'(1);
        end
      end else begin
        r_h_cnt <= r_h_cnt + CW'(1);
      end
    end
  end

  // Output stage: pixel, syncs and frame tick aligned one cycle after x/y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync      <= ~SYNC_POL;
      r_vsync      <= ~SYNC_POL;
      r_rgb        <= '0;
      r_frame_tick <= 1'b0;
    end else if (ena) begin
      r_hsync      <= w_hs_on ? SYNC_POL : ~SYNC_POL;
      r_vsync      <= w_vs_on ? SYNC_POL : ~SYNC_POL;
      r_rgb        <= w_pix;
      r_frame_tick <= w_tick;
    end else begin
      r_frame_tick <= 1'b0;
    end
  end

  assign x          = r_h_cnt;
  assign y          = r_v_cnt;
  assign active     = w_active;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign rgb        = r_rgb;
  assign frame_tick = r_frame_tick;
  assign frame_cnt  = r_frame_cnt;
  // PMOD order {hsync,B0,G0,R0,vsync,B1,G1,R1} with rgb = {R1,R0,G1,G0,B1,B0}.
  assign uo_out     = {r_hsync, r_rgb[0], r_rgb[2], r_rgb[4], r_vsync, r_rgb[1], r_rgb[3], r_rgb[5]};

endmodule

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench for vga_scan_gen: a frame-position model predicts x/y/active and the
// registered outputs; monitors compare them against the DUT on opposite clock phases.
module tb_vga_scan_gen;

  localparam int unsigned TH_ACTIVE = 640;
  localparam int unsigned TH_FP     = 16;
  localparam int unsigned TH_SYNC   = 96;
  localparam int unsigned TH_BP     = 48;
  localparam int unsigned TV_ACTIVE = 12;
  localparam int unsigned TV_FP     = 3;
  localparam int unsigned TV_SYNC   = 2;
  localparam int unsigned TV_BP     = 3;
  localparam int unsigned TH_TOTAL  = TH_ACTIVE + TH_FP + TH_SYNC + TH_BP;
  localparam int unsigned TV_TOTAL  = TV_ACTIVE + TV_FP + TV_SYNC + TV_BP;
  localparam int unsigned FRAME     = TH_TOTAL * TV_TOTAL;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b0;
  logic       draw_in = 1'b0;
  logic [5:0] rgb_in = '0;
  logic [9:0] x;
  logic [9:0] y;
  logic       active;
  logic       hsync;
  logic       vsync;
  logic [5:0] rgb;
  logic [7:0] uo_out;
  logic       frame_tick;
  logic [7:0] frame_cnt;

  vga_scan_gen #(
    .H_ACTIVE(TH_ACTIVE), .H_FP(TH_FP), .H_SYNC(TH_SYNC), .H_BP(TH_BP),
    .V_ACTIVE(TV_ACTIVE), .V_FP(TV_FP), .V_SYNC(TV_SYNC), .V_BP(TV_BP),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .x(x), .y(y), .active(active),
    .draw_in(draw_in), .rgb_in(rgb_in), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .uo_out(uo_out), .frame_tick(frame_tick), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
  } comb_t;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [5:0] rgb;
    logic       tick;
    logic [7:0] fc;
  } regs_t;

  comb_t q_comb[$];
  regs_t q_reg[$];

  int total = 0;
  int bad   = 0;
  int ticks_seen = 0;

  // Model state: linear position inside the frame plus last registered outputs.
  int         m_p;
  logic       m_hs, m_vs, m_tick;
  logic [5:0] m_rgb;
  logic [7:0] m_fc;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pmod(input logic hs, input logic vs, input logic [5:0] c);
    logic [1:0] r, g, b;
    r = c[5:4]; g = c[3:2]; b = c[1:0];
    return {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
  endfunction

  function automatic logic [5:0] background(input int px);
    int bar;
    bar = (px / 64) % 8;
`ifdef VGA_SCAN_TEST_PATTERN_EN
    return {bar[2], bar[2], bar[1], bar[1], bar[0], bar[0]};
`else
    return (bar < 0) ? 6'b111111 : 6'b000000;
`endif
  endfunction

  function automatic int mx();
    return m_p % TH_TOTAL;
  endfunction

  function automatic int my();
    return m_p / TH_TOTAL;
  endfunction

  task automatic model_reset();
    m_p = 0; m_hs = 1'b1; m_vs = 1'b1; m_tick = 1'b0; m_rgb = '0; m_fc = '0;
  endtask

  // One pixel-clock cycle of stimulus; expectations go into the scoreboard queues.
  task automatic step(input logic en, input logic dr, input logic [5:0] c);
    int cx, cy;
    logic act;
    @(negedge clk);
    ena = en; draw_in = dr; rgb_in = c;
    cx = mx(); cy = my();
    act = (cx < int'(TH_ACTIVE)) && (cy < int'(TV_ACTIVE));
    q_comb.push_back('{x: 10'(cx), y: 10'(cy), act: act});
    if (en) begin
      m_hs   = !(cx >= int'(TH_ACTIVE + TH_FP) && cx < int'(TH_ACTIVE + TH_FP + TH_SYNC));
      m_vs   = !(cy >= int'(TV_ACTIVE + TV_FP) && cy < int'(TV_ACTIVE + TV_FP + TV_SYNC));
      m_rgb  = !act ? 6'b000000 : (dr ? c : background(cx));
      m_tick = (cx == 0) && (cy == int'(TV_ACTIVE));
      m_p    = m_p + 1;
      if (m_p == int'(FRAME)) begin
        m_p  = 0;
        m_fc = m_fc + 8'd1;
      end
    end else begin
      m_tick = 1'b0;
    end
    q_reg.push_back('{hs: m_hs, vs: m_vs, rgb: m_rgb, tick: m_tick, fc: m_fc});
  endtask

  task automatic rand_step(input int ena_pct);
    step(($urandom_range(99) < ena_pct) ? 1'b1 : 1'b0, 1'($urandom), 6'($urandom));
  endtask

  // Asynchronous reset between clock edges; outputs must clear without a clock.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    q_reg.delete();
    #1;
    chk({tag, "_x"}, int'(x), 0);
    chk({tag, "_y"}, int'(y), 0);
    chk({tag, "_hsync"}, int'(hsync), 1);
    chk({tag, "_vsync"}, int'(vsync), 1);
    chk({tag, "_rgb"}, int'(rgb), 0);
    chk({tag, "_tick"}, int'(frame_tick), 0);
    chk({tag, "_fcnt"}, int'(frame_cnt), 0);
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Combinational monitor: x/y/active checked just after the falling edge.
  initial begin
    comb_t e;
    forever begin
      @(negedge clk);
      #1;
      if (q_comb.size() > 0) begin
        e = q_comb.pop_front();
        chk("x", int'(x), int'(e.x));
        chk("y", int'(y), int'(e.y));
        chk("active", int'(active), int'(e.act));
      end
    end
  end

  // Registered-output monitor: checked just after the rising edge.
  initial begin
    regs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_reg.size() > 0) begin
        e = q_reg.pop_front();
        chk("hsync", int'(hsync), int'(e.hs));
        chk("vsync", int'(vsync), int'(e.vs));
        chk("rgb", int'(rgb), int'(e.rgb));
        chk("frame_tick", int'(frame_tick), int'(e.tick));
        chk("frame_cnt", int'(frame_cnt), int'(e.fc));
        chk("uo_out", int'(uo_out), int'(pmod(e.hs, e.vs, e.rgb)));
        if (frame_tick) ticks_seen++;
      end
    end
  end

  initial begin
    int n;
    model_reset();
    #7;
    do_reset("rst0");

    // First line and the wrap into line 1 at full enable.
    for (int i = 0; i < TH_TOTAL + 20; i++) rand_step(100);

    // Constant overlay colour across a full frame plus extra random cycles.
    for (int i = 0; i < FRAME; i++) step(1'b1, 1'b1, 6'b110110);
    for (int i = 0; i < FRAME + 3000; i++) rand_step(90);

    // Freeze for five cycles at column 100.
    n = 0;
    while (mx() != 100 && n < 2 * TH_TOTAL) begin
      rand_step(100);
      n++;
    end
    chk("reach_x100", mx(), 100);
    for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom), 6'($urandom));
    for (int i = 0; i < 10; i++) rand_step(100);

    // Reset while both syncs are asserted.
    n = 0;
    while (!(mx() == 700 && my() == int'(TV_ACTIVE + TV_FP)) && n < 2 * int'(FRAME)) begin
      rand_step(100);
      n++;
    end
    chk("reach_sync_pt", m_p, 700 + int'(TH_TOTAL * (TV_ACTIVE + TV_FP)));
    @(posedge clk);
    #2;
    chk("pre_rst_hsync", int'(hsync), 0);
    chk("pre_rst_vsync", int'(vsync), 0);
    chk("pre_rst_x", int'(x), 700);
    do_reset("rst_mid");
    for (int i = 0; i < TH_TOTAL + 50; i++) rand_step(85);

    @(negedge clk);
    ena = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", q_reg.size() + q_comb.size(), 0);
    chk("ticks_seen_min", (ticks_seen >= 2) ? 1 : 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
